// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder and its storage array.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wide enough for the full legal WAIT_CYCLES range (0..15).
  localparam int unsigned CNT_W = 4;

  // Word-index width; clamped to 1 so a single-word array still has an index bit.
  function automatic int unsigned idx_w(input int unsigned depth_words);
    return (depth_words > 1) ? $clog2(depth_words) : 1;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read, no reset on contents.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 128
) (
  input  logic                           clk_i,
  input  logic                           we_i,
  input  logic                           re_i,
  input  logic [idx_w(DEPTH_WORDS)-1:0]  idx_i,
  input  logic [DATA_W-1:0]              wdata_i,
  output logic [DATA_W-1:0]              rdata_o
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[idx_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem[idx_i];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one command at a time, WAIT_CYCLES wait states, then a
// response held until the requester consumes it.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 128,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o
);

  localparam int unsigned IDX_W = idx_w(DEPTH_WORDS);

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              ready_q;
  logic              err_q;
  logic              load_q;
  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              access;
  logic              addr_bad;
  logic [ADDR_W-1:0] word_addr;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  assign accept    = (state == IDLE) && ready_q && req_valid_i;
  assign access    = (state == WAIT) && (cnt == '0);
  assign word_addr = addr_q >> 2;
  assign addr_bad  = (addr_q[1:0] != 2'b00) || (word_addr >= ADDR_W'(DEPTH_WORDS));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; WAIT_CYCLES=0 still passes through WAIT for exactly one edge.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = WAIT;
      WAIT:    if (cnt == '0) state_nx = RESP;
      RESP:    if (rsp_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      ready_q <= (state_nx == IDLE);
      if (accept) begin
        cnt <= CNT_W'(WAIT_CYCLES);
      end else if ((state == WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (access) begin
        err_q  <= addr_bad;
        load_q <= !write_q && !addr_bad;
      end else if ((state == RESP) && rsp_ready_i) begin
        err_q  <= 1'b0;
        load_q <= 1'b0;
      end
    end
  end

  // Command capture; contents only matter once a command has been accepted.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      write_q <= req_write_i;
      addr_q  <= req_addr_i;
      wdata_q <= req_wdata_i;
    end
  end

  // Output decode. Read data sits in the array's output register, which only
  // updates on the access edge, so it stays stable for the whole RESP phase.
  always_comb begin
    req_ready_o = ready_q;
    rsp_valid_o = (state == RESP);
    rsp_err_o   = err_q;
    rsp_rdata_o = load_q ? mem_rdata : '0;
    mem_we      = access && write_q && !addr_bad;
    mem_re      = access && !write_q && !addr_bad;
  end

  dmem_array #(
    .DATA_W      (DATA_W),
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk_i   (clk_i),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .idx_i   (addr_q[IDX_W+1:2]),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance against a
// word-array reference model.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_write [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];

  int unsigned errors = 0;
  int unsigned checks = 0;

  logic [31:0] mem_m [2][128];
  bit          known [2][128];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  vec_t tbl [13];

  dmem_responder #(.WAIT_CYCLES(2)) u_w2 (
    .clk_i(clk), .rst_i(rst[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]), .req_write_i(req_write[0]),
    .req_addr_i(req_addr[0]), .req_wdata_i(req_wdata[0]),
    .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready[0]),
    .rsp_rdata_o(rsp_rdata[0]), .rsp_err_o(rsp_err[0])
  );

  dmem_responder #(.WAIT_CYCLES(0)) u_w0 (
    .clk_i(clk), .rst_i(rst[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]), .req_write_i(req_write[1]),
    .req_addr_i(req_addr[1]), .req_wdata_i(req_wdata[1]),
    .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready[1]),
    .rsp_rdata_o(rsp_rdata[1]), .rsp_err_o(rsp_err[1])
  );

  function automatic int wc(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: a word is addressable only when aligned and below 128 words.
  task automatic model_txn(input int d, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output bit er);
    int w;
    er = (a % 4 != 0) || (a / 4 >= 128);
    rd = '0;
    if (!er) begin
      w = int'(a / 4);
      if (wr) begin
        mem_m[d][w] = wd;
        known[d][w] = 1'b1;
      end else begin
        rd = mem_m[d][w];
      end
    end
  endtask

  // One full transaction; called and returns at #1 after a rising edge.
  task automatic txn(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                     input int hold, output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] rd0;
    logic        e0;
    req_write[d] = wr;
    req_addr[d]  = a;
    req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    n = 0;
    while (req_ready[d] !== 1'b1) begin
      if (n == 20) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout: req_ready=%b expected 1", req_ready[d]);
        req_valid[d] = 1'b0;
        rd = 'x;
        er = 1'bx;
        return;
      end
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    req_wdata[d] = 32'hBAD0BAD0;
    chk("ready_low_after_accept", 32'(req_ready[d]), 32'd0);
    n = 0;
    while (rsp_valid[d] !== 1'b1 && n < 20) begin
      rsp_ready[d] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    rsp_ready[d] = 1'b0;
    chk("latency", n, wc(d) + 1);
    rd0 = rsp_rdata[d];
    e0  = rsp_err[d];
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = 1'b1;
      req_write[d] = 1'b1;
      req_addr[d]  = a;
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", rsp_rdata[d], rd0);
      chk("hold_err", 32'(rsp_err[d]), 32'(e0));
      chk("hold_ready", 32'(req_ready[d]), 32'd0);
    end
    req_valid[d] = 1'b0;
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk("valid_drop", 32'(rsp_valid[d]), 32'd0);
    chk("ready_back", 32'(req_ready[d]), 32'd1);
    rd = rd0;
    er = e0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, erd;
    logic        er;
    bit          eer;

    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 0, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        5, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h13,  32'h11111111, 1, 32'h0,        1'b1};
    tbl[3]  = '{1'b0, 32'h200, 32'h0,        2, 32'h0,        1'b1};
    tbl[4]  = '{1'b0, 32'h10,  32'h0,        0, 32'hDEADBEEF, 1'b0};
    tbl[5]  = '{1'b1, 32'h20,  32'hCAFEF00D, 0, 32'h0,        1'b0};
    tbl[6]  = '{1'b1, 32'h0,   32'h01020304, 0, 32'h0,        1'b0};
    tbl[7]  = '{1'b1, 32'h200, 32'hFFFFFFFF, 0, 32'h0,        1'b1};
    tbl[8]  = '{1'b0, 32'h0,   32'h0,        1, 32'h01020304, 1'b0};
    tbl[9]  = '{1'b1, 32'h1FC, 32'hA5A5A5A5, 0, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 32'h1FC, 32'h0,        3, 32'hA5A5A5A5, 1'b0};
    tbl[11] = '{1'b0, 32'h1E,  32'h0,        0, 32'h0,        1'b1};
    tbl[12] = '{1'b0, 32'h20,  32'h0,        0, 32'hCAFEF00D, 1'b0};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
      for (int w = 0; w < 128; w++) begin
        mem_m[d][w] = '0;
        known[d][w] = 1'b0;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", 32'(req_ready[d]), 32'd0);
      chk("rst_valid", 32'(rsp_valid[d]), 32'd0);
      chk("rst_err", 32'(rsp_err[d]), 32'd0);
      chk("rst_rdata", rsp_rdata[d], 32'd0);
      rst[d] = 1'b0;
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      chk("ready_after_rst", 32'(req_ready[d]), 32'd1);
      chk("valid_after_rst", 32'(rsp_valid[d]), 32'd0);
    end

    foreach (tbl[i]) begin
      txn(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].hold, rd, er);
      chk("tbl_rdata", rd, tbl[i].exp_rdata);
      chk("tbl_err", 32'(er), 32'(tbl[i].exp_err));
      model_txn(0, tbl[i].wr, tbl[i].addr, tbl[i].wdata, erd, eer);
    end

    // Reset lands while a store is still counting down; it must never commit.
    chk("pre_abort_ready", 32'(req_ready[0]), 32'd1);
    req_write[0] = 1'b1; req_addr[0] = 32'h20; req_wdata[0] = 32'h12345678; req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", 32'(rsp_valid[0]), 32'd0);
    chk("abort_ready", 32'(req_ready[0]), 32'd0);
    rst[0] = 1'b0;
    @(posedge clk); #1;
    chk("abort_ready_back", 32'(req_ready[0]), 32'd1);
    txn(0, 1'b0, 32'h20, 32'h0, 0, rd, er);
    chk("abort_load", rd, 32'hCAFEF00D);
    chk("abort_err", 32'(er), 32'd0);

    // Zero-wait build: back-to-back store then load.
    txn(1, 1'b1, 32'h40, 32'h55AA55AA, 0, rd, er);
    chk("w0_store_rdata", rd, 32'h0);
    chk("w0_store_err", 32'(er), 32'd0);
    model_txn(1, 1'b1, 32'h40, 32'h55AA55AA, erd, eer);
    txn(1, 1'b0, 32'h40, 32'h0, 0, rd, er);
    chk("w0_load_rdata", rd, 32'h55AA55AA);
    chk("w0_load_err", 32'(er), 32'd0);
    model_txn(1, 1'b0, 32'h40, 32'h0, erd, eer);

    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 40; k++) begin
        int unsigned kind, widx;
        logic [31:0] a, wd;
        bit wr;
        widx = 64 + $urandom_range(0, 15);
        kind = $urandom_range(0, 7);
        wr   = 1'($urandom_range(0, 1));
        wd   = $urandom;
        if (kind == 0) begin
          a = (widx * 4) | $urandom_range(1, 3);
        end else if (kind == 1) begin
          a = 32'h200 + 4 * $urandom_range(0, 1000);
        end else begin
          a = widx * 4;
          if (!wr && !known[d][widx]) wr = 1'b1;
        end
        model_txn(d, wr, a, wd, erd, eer);
        txn(d, wr, a, wd, int'($urandom_range(0, 3)), rd, er);
        chk("rnd_rdata", rd, erd);
        chk("rnd_err", 32'(er), 32'(eer));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's data-memory port. Replaces the zero-latency combinational data memory with a request/response handshake and configurable wait states.
- Accepts one load or store at a time, holds it for WAIT_CYCLES, performs the access, then presents a response until the requester consumes it.
- Sits between the MEM stage (the initiator, which stalls on handshake) and the word-organised storage array.

Parameters:
- ADDR_W, 32, request address width (byte address).
- DATA_W, 32, data word width.
- DEPTH_WORDS, 128, number of words in storage; valid byte range is 0 .. 4*DEPTH_WORDS-1.
- WAIT_CYCLES, 2, cycles between request accept and the access taking effect; legal range 0..15.

Ports:
- clk_i  in  1  clock, all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i  in  1  requester presents a command.
- req_ready_o  out  1  responder can accept a command this cycle.
- req_write_i  in  1  1 = store, 0 = load.
- req_addr_i  in  ADDR_W  byte address.
- req_wdata_i  in  DATA_W  store data.
- rsp_valid_o  out  1  response available.
- rsp_ready_i  in  1  requester consumes the response.
- rsp_rdata_o  out  DATA_W  load data; 0 for stores and for errors.
- rsp_err_o  out  1  access rejected (misaligned or out of range).

Behaviour:
- FSM states: IDLE, WAIT, RESP. All outputs are registered or decoded from state only; there is no combinational path from req_* or rsp_ready_i to any output.
- Reset (rst_i=1 at an edge):
  - state goes to IDLE; wait counter goes to 0.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - req_ready_o=0 while rst_i is high, and 1 from the first edge after rst_i falls.
  - Storage contents are not affected by reset.
- IDLE:
  - req_ready_o=1.
  - Accept when req_valid_i and req_ready_o are both 1 at an edge; latch write, addr and wdata.
  - Go to WAIT with counter=WAIT_CYCLES, or directly to an access when WAIT_CYCLES=0.
- WAIT:
  - req_ready_o=0; the counter decrements each edge.
  - When the counter reaches 0, the access is performed on that edge:
    - Store: writes mem[addr>>2].
    - Load: captures mem[addr>>2] into rsp_rdata_o.
  - Then go to RESP with rsp_valid_o=1.
- Latency: accept at edge N gives rsp_valid_o=1 after edge N+WAIT_CYCLES+1.
- RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o stay stable until the handshake.
  - On rsp_valid_o and rsp_ready_i both 1: go to IDLE, rsp_valid_o=0, and req_ready_o=1 in the next cycle.
  - There is no same-cycle accept of a new request in RESP.
- Error rule: if addr[1:0]!=0 or (addr>>2)>=DEPTH_WORDS:
  - No storage write occurs.
  - rsp_rdata_o=0 and rsp_err_o=1.
  - Latency is identical to a normal access.
- Stores: rsp_rdata_o=0, rsp_err_o=0 unless an error applies.
- req_valid_i while req_ready_o=0 is ignored; the requester must hold it.
- rsp_ready_i outside RESP is ignored.
- Reset in WAIT aborts the command. A store not yet committed never reaches storage.
- Store followed by a load to the same address returns the new data; there is always at least one full transaction between them.

Decomposition:
- Shared package dmem_pkg holds:
  - state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - WAIT counter width constant (4 bits);
  - word-index helper width, $clog2(DEPTH_WORDS).
- One sub-module, dmem_array: single-port synchronous-write, registered-read word storage with params DATA_W and DEPTH_WORDS.

Test Plan:
- Reset, WAIT_CYCLES=2 -> rsp_valid_o=0, rsp_err_o=0, req_ready_o=1 one cycle after rst_i drops.
- Store addr 0x10 data 0xDEADBEEF, accepted at edge N, rsp_ready_i=1 -> rsp_valid_o high after edge N+3, err=0, rdata=0; then load 0x10 -> rdata=0xDEADBEEF.
- Load completes with rsp_ready_i held low 5 cycles -> rsp_valid_o and rdata stay stable all 5 cycles, req_ready_o=0 throughout; new req_valid_i is ignored until the handshake.
- Store to 0x13 (misaligned) and load 0x200 (out of range, DEPTH 128) -> both err=1, rdata=0; a later load 0x10 still returns the prior value.
- rst_i pulsed during WAIT of a store 0x20 data 0x12345678 -> a following load of 0x20 returns the old value (0x0 if never written).
- WAIT_CYCLES=0 build: back-to-back store/load with rsp_ready_i=1 -> each response valid one edge after accept, with one idle cycle between transactions.
